// File: rtl/axis_channel_loader.sv
// axis_channel_loader
// Takes one AXI-Stream burst from the PS/DMA and routes it to one of N_CH
// channel drivers. The target channel's select line is held high for the
// whole load, so its loopback mux takes the PS input. A single output
// register stage gives one cycle of latency at full throughput. The block
// counts the accepted beats and pulses done when the last beat has left.
//
// cfg_chan is one bit wider than log2(N_CH). This lets an out-of-range
// channel number reach the block, be detected, and be reported on cfg_err
// instead of silently aliasing onto a real channel.

module axis_channel_loader #(
    parameter int DATA_W = 256,
    parameter int N_CH   = 16,
    parameter int CNT_W  = 16,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int CHAN_W = SEL_W + 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [CNT_W-1:0]  cfg_beats,
    input  logic              cfg_start,

    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,

    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [N_CH-1:0]   m_axis_tvalid,
    input  logic [N_CH-1:0]   m_axis_tready,

    output logic [N_CH-1:0]   chan_select,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // N_CH widened to the compare width so the range check works for any N_CH.
    localparam logic [CHAN_W:0] N_CH_LIM = (CHAN_W + 1)'(N_CH);

    // Control state.
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    // High for a load that actually carries beats. It gates chan_select, so a
    // zero-beat load never raises a select line.
    logic               load_q, load_d;
    logic               err_q, err_d;

    // Output register stage.
    logic [DATA_W-1:0]  odata_q, odata_d;
    logic               ovalid_q, ovalid_d;

    // Handshake terms.
    logic [N_CH-1:0]    sel_onehot;
    logic               sel_ready;
    logic               out_retire;
    logic               in_ready;
    logic               in_accept;
    logic               chan_ok;

    assign sel_onehot = N_CH'(1) << sel_q;
    // Ready from the non-selected channels never reaches the datapath.
    assign sel_ready  = m_axis_tready[sel_q];
    assign out_retire = ovalid_q && sel_ready;

    // The input can be taken when beats remain and the output register is
    // either empty or being emptied this cycle. Loading and retiring in the
    // same cycle keeps one beat per clock.
    assign in_ready   = (state_q == S_ROUTE) && (rem_q != '0) &&
                        (!ovalid_q || sel_ready);
    assign in_accept  = in_ready && s_axis_tvalid;

    assign chan_ok    = {1'b0, cfg_chan} < N_CH_LIM;

    // Next state for the load sequencer and the sticky config error.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        load_d  = load_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (chan_ok) begin
                        sel_d  = cfg_chan[SEL_W-1:0];
                        rem_d  = cfg_beats;
                        load_d = (cfg_beats != '0);
                        state_d = (cfg_beats != '0) ? S_ROUTE : S_DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ROUTE: begin
                // rem is never zero here, so this decrement cannot wrap.
                if (in_accept) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!ovalid_q || out_retire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                load_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                load_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: a new beat replaces or refills it, and a retire
    // with no new beat empties it.
    always_comb begin
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        if (in_accept) begin
            odata_d  = s_axis_tdata;
            ovalid_d = 1'b1;
        end else if (out_retire) begin
            ovalid_d = 1'b0;
        end
    end

    // State and datapath registers. The data register is also cleared, so
    // m_axis_tdata reads zero after reset. A reset during a load drops the
    // beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            rem_q    <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rem_q    <= rem_d;
            load_q   <= load_d;
            err_q    <= err_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign s_axis_tready = in_ready;
    assign m_axis_tdata  = odata_q;
    assign m_axis_tvalid = ovalid_q ? sel_onehot : '0;
    assign chan_select   = load_q ? sel_onehot : '0;
    assign busy          = (state_q == S_ROUTE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_axis_channel_loader.sv
// Directed bench for axis_channel_loader. Each load is driven cycle by cycle.
// Output beats, the select lines, stall behaviour and the done pulse are
// compared with hand-derived expectations.

module tb_axis_channel_loader;

    localparam int DATA_W = 256;
    localparam int N_CH   = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        cfg_chan;
    logic [CNT_W-1:0]  cfg_beats;
    logic              cfg_start;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [N_CH-1:0]   m_axis_tvalid;
    logic [N_CH-1:0]   m_axis_tready;
    logic [N_CH-1:0]   chan_select;
    logic              busy;
    logic              done;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_channel_loader #(
        .DATA_W(DATA_W),
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_chan     (cfg_chan),
        .cfg_beats    (cfg_beats),
        .cfg_start    (cfg_start),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .chan_select  (chan_select),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] beat_word(input int tag, input int k);
        logic [31:0]       w;
        logic [DATA_W-1:0] r;
        w = 32'hC0DE0000 | 32'(tag << 8) | 32'(k);
        for (int j = 0; j < DATA_W / 32; j++) r[j*32 +: 32] = w ^ 32'(j);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sready"}, DATA_W'(s_axis_tready), '0);
        check({tag, "_mvalid"}, DATA_W'(m_axis_tvalid), '0);
        check({tag, "_select"}, DATA_W'(chan_select), '0);
        check({tag, "_busy"},   DATA_W'(busy), '0);
        check({tag, "_done"},   DATA_W'(done), '0);
    endtask

    // mode 0: selected ready held 1; mode 1: selected ready 1,0,0,1,0,0...
    // Non-selected readies are held 1 so any leakage from them would show.
    // rst_after > 0: reset once that many input beats have been accepted.
    // restart_iter >= 0: pulse cfg_start (chan 7, 9 beats) at that cycle.
    task automatic run_load(input int chan, input int beats, input int mode,
                            input int rst_after, input int restart_iter, input int tag);
        int in_cnt = 0, out_cnt = 0, done_cnt = 0;
        int first_in = -1, first_out = -1, last_out = -1, done_ci = -1;
        logic done_seen = 1'b0;
        logic held_v = 1'b0;
        logic [DATA_W-1:0] held = '0;
        logic [N_CH-1:0] onehot;
        logic [N_CH-1:0] sel_exp;
        onehot = N_CH'(1) << chan;

        tick();
        cfg_start = 1'b1;
        cfg_chan  = 5'(chan);
        cfg_beats = CNT_W'(beats);
        s_axis_tvalid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            tick();
            cfg_start = 1'b0;
            if (i == restart_iter) begin
                cfg_start = 1'b1;
                cfg_chan  = 5'd7;
                cfg_beats = CNT_W'(9);
            end
            if (rst_after > 0 && in_cnt == rst_after) begin
                s_axis_tvalid = 1'b0;
                rst = 1'b1;
                tick();
                #1;
                check_all_zero("rst_mid");
                check("rst_mid_tdata", m_axis_tdata, '0);
                check("rst_mid_err", DATA_W'(cfg_err), '0);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    #1;
                    check("rst_nodone", DATA_W'(done), '0);
                    check("rst_idle_sel", DATA_W'(chan_select), '0);
                end
                return;
            end
            // Valid stays high past the burst to show extra data is refused.
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beat_word(tag, in_cnt);
            m_axis_tready = '1;
            if (mode == 1) m_axis_tready[chan] = (i % 3 == 0);
            #1;

            sel_exp = (beats != 0 && !done_seen) ? onehot : '0;
            check("chan_select", DATA_W'(chan_select), DATA_W'(sel_exp));
            check("busy", DATA_W'(busy), DATA_W'(beats != 0 && !done_seen && !done));
            check("tvalid_onehot", DATA_W'(m_axis_tvalid & ~onehot), '0);
            if (held_v) check("stall_hold", m_axis_tdata, held);
            held_v = m_axis_tvalid[chan] && !m_axis_tready[chan];
            held   = m_axis_tdata;
            if (held_v) check("stall_sready", DATA_W'(s_axis_tready), '0);
            if (m_axis_tvalid[chan] && m_axis_tready[chan]) begin
                check("beat_data", m_axis_tdata, beat_word(tag, out_cnt));
                if (out_cnt == 0) first_out = i;
                last_out = i;
                out_cnt++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (in_cnt == 0) first_in = i;
                in_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (!done_seen) done_ci = i;
                done_seen = 1'b1;
            end
            if (done_seen && i >= done_ci + 2) break;
        end

        s_axis_tvalid = 1'b0;
        check("done_seen", DATA_W'(done_seen), DATA_W'(1));
        check("done_count", DATA_W'(done_cnt), DATA_W'(1));
        check("in_count", DATA_W'(in_cnt), DATA_W'(beats));
        check("out_count", DATA_W'(out_cnt), DATA_W'(beats));
        if (beats == 0) begin
            check("done_at_start", DATA_W'(done_ci), '0);
        end else begin
            check("done_after_last", DATA_W'(done_ci), DATA_W'(last_out + 1));
            if (mode == 0) begin
                check("latency", DATA_W'(first_out), DATA_W'(first_in + 1));
                check("back_to_back", DATA_W'(last_out - first_out), DATA_W'(beats - 1));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        cfg_chan      = '0;
        cfg_beats     = '0;
        cfg_start     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = '0;
        repeat (3) tick();
        #1;
        check_all_zero("reset");
        check("reset_tdata", m_axis_tdata, '0);
        check("reset_err", DATA_W'(cfg_err), '0);
        rst = 1'b0;
        tick();

        // Channel 3, 4 beats, full throughput.
        run_load(3, 4, 0, 0, -1, 1);
        // Channel 15, 3 beats, downstream stalls.
        run_load(15, 3, 1, 0, -1, 2);
        // Zero-beat load.
        run_load(5, 0, 0, 0, -1, 3);

        // Out-of-range channel.
        tick();
        cfg_start = 1'b1;
        cfg_chan  = 5'd16;
        cfg_beats = CNT_W'(4);
        s_axis_tvalid = 1'b1;
        m_axis_tready = '1;
        for (int k = 0; k < 3; k++) begin
            tick();
            cfg_start = 1'b0;
            #1;
            check("bad_chan_err", DATA_W'(cfg_err), DATA_W'(1));
            check_all_zero("bad_chan");
        end
        s_axis_tvalid = 1'b0;
        run_load(9, 2, 0, 0, -1, 4);
        check("err_sticky", DATA_W'(cfg_err), DATA_W'(1));

        // Reset after 2 of 8 beats, then a clean load.
        run_load(6, 8, 0, 2, -1, 5);
        run_load(0, 2, 0, 0, -1, 6);

        // cfg_start during ROUTE is ignored.
        run_load(12, 5, 0, 0, 1, 7);
        check("restart_no_err", DATA_W'(cfg_err), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
